dds_phase_accumulator: RTL

Numerically controlled phase accumulator with a click-free amplitude ramp, sitting directly upstream of the DDS phase-to-angle converter. It produces the 9-bit phase_in and amplitude_in words that the converter consumes. Frequency tuning words arrive through a valid/ready handshake and take effect glitch-free on the next phase wrap. Amplitude ramps linearly up to a target on enable and back down to zero on disable, so the DAC output never steps.

---
 rtl/dds_pkg.sv | 7 +
 rtl/dds_phase_accumulator_if.sv | 8 +
 rtl/dds_amp_ramp.sv | 59 +++++
 rtl/dds_phase_accumulator.sv | 60 ++++++
 4 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and ramp FSM state type for the DDS phase accumulator
package dds_pkg;
    localparam int N_DEF = 8;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {IDLE, RAMP, HOLD, DRAIN} ramp_state_t;
endpackage

// File: rtl/dds_phase_accumulator_if.sv
// dds_phase_accumulator_if: frequency tuning word valid/ready handshake
interface dds_phase_accumulator_if #(parameter int ACC_W = 24) ();
    logic [ACC_W-1:0] ftw_in;
    logic ftw_valid;
    logic ftw_ready;
    modport master (output ftw_in, ftw_valid, input ftw_ready);
    modport slave (input ftw_in, ftw_valid, output ftw_ready);
endinterface

// File: rtl/dds_amp_ramp.sv
// dds_amp_ramp: click-free linear amplitude ramp FSM with clock divider
module dds_amp_ramp
    import dds_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int RAMP_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [N:0] amp_target,
    output logic [N:0] amplitude,
    output logic       active
);
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(RAMP_DIV - 1);
    ramp_state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [N:0] amp_nx;
    logic step;
    assign step = cnt == DIV_M1;
    assign active = state != IDLE;
    always_comb begin
        state_nx = state;
        amp_nx = amplitude;
        case (state)
            IDLE: if (enable) state_nx = RAMP;
            RAMP: begin
                if (!enable) state_nx = DRAIN;
                else if (amplitude == amp_target) state_nx = HOLD;
                else if (step) begin
                    amp_nx = amplitude < amp_target ? amplitude + 1'b1 : amplitude - 1'b1;
                    if (amp_nx == amp_target) state_nx = HOLD;
                end
            end
            HOLD: state_nx = !enable ? DRAIN : (amplitude != amp_target ? RAMP : HOLD);
            DRAIN: begin
                if (enable) state_nx = RAMP;
                else if (amplitude == '0) state_nx = IDLE;
                else if (step) begin
                    amp_nx = amplitude - 1'b1;
                    if (amp_nx == '0) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        cnt_nx = (state_nx != state || step) ? '0 : cnt + 1'b1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            amplitude <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            amplitude <= amp_nx;
        end
    end
endmodule

// File: rtl/dds_phase_accumulator.sv
// dds_phase_accumulator: NCO phase accumulator with wrap-synchronous FTW update and amplitude ramp
module dds_phase_accumulator
    import dds_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int RAMP_DIV = 4,
    parameter int SYNC_UPDATE = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    dds_phase_accumulator_if.slave  ftw,
    input  logic [N:0]              phase_offset,
    input  logic [N:0]              amp_target,
    output logic [N:0]              phase_out,
    output logic [N:0]              amplitude_out,
    output logic                    sample_valid,
    output logic                    wrap_pulse
);
    logic [ACC_W-1:0] acc, ftw_active, ftw_pending;
    logic [ACC_W:0] sum;
    logic pend, carry, active, take, apply;
    assign sum = {1'b0, acc} + {1'b0, ftw_active};
    assign carry = active & sum[ACC_W];
    assign take = ftw.ftw_valid & ~pend;
    // a word taken on a carry cycle has pend=0 there, so it waits for the next wrap
    assign apply = pend && (SYNC_UPDATE == 0 || carry || !active);
    assign ftw.ftw_ready = ~pend;
    assign sample_valid = active;
    dds_amp_ramp #(.N(N), .RAMP_DIV(RAMP_DIV)) u_ramp (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .amp_target(amp_target),
        .amplitude(amplitude_out),
        .active(active)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            ftw_active <= '0;
            ftw_pending <= '0;
            pend <= 1'b0;
            phase_out <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            acc <= active ? sum[ACC_W-1:0] : '0;
            wrap_pulse <= carry;
            phase_out <= acc[ACC_W-1 -: N+1] + phase_offset;
            if (take) begin
                ftw_pending <= ftw.ftw_in;
                pend <= 1'b1;
            end else if (apply) begin
                ftw_active <= ftw_pending;
                pend <= 1'b0;
            end
        end
    end
endmodule
